// File: rtl/mesi_mem_responder.sv
// Fixed-latency 128-bit line memory answering the MESI cache-side memory port.
// Define MEM_STATS_EN to build saturating read/write completion counters.
module mesi_mem_responder #(
  parameter int LINES   = 256,
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [127:0]      mem_write_data,
  output logic              mem_busy,
  output logic [127:0]      mem_read_data,
  output logic              mem_ready,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);
  localparam int IDX_W = $clog2(LINES);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_r;
  logic               we_r;
  logic [IDX_W-1:0]   idx_r;
  logic [127:0]       wdata_r;
  logic [LAT_W-1:0]   lat_cnt_r;
  logic [127:0]       mem_r [LINES];
  logic               fire_s;
  logic               unused_s;

  // The edge that ends the last WAIT cycle is the edge entering RESP.
  assign fire_s   = (state_r == WAIT) && (lat_cnt_r == {LAT_W{1'b0}});
  assign unused_s = ^{mem_addr[ADDR_W-1:IDX_W+4], mem_addr[3:0]};

  // Request sequencing; RESP is the single cycle in which mem_ready is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      mem_busy      <= 1'b0;
      mem_ready     <= 1'b0;
      mem_read_data <= 128'd0;
      we_r          <= 1'b0;
      idx_r         <= {IDX_W{1'b0}};
      wdata_r       <= 128'd0;
      lat_cnt_r     <= {LAT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          mem_ready <= 1'b0;
          if (mem_req) begin
            we_r      <= mem_we;
            idx_r     <= mem_addr[IDX_W+3:4];
            wdata_r   <= mem_write_data;
            lat_cnt_r <= LAT_LOAD;
            state_r   <= WAIT;
            mem_busy  <= 1'b1;
          end else begin
            mem_busy  <= 1'b0;
          end
        end
        WAIT: begin
          if (lat_cnt_r == {LAT_W{1'b0}}) begin
            state_r   <= RESP;
            mem_ready <= 1'b1;
            if (!we_r) begin
              mem_read_data <= mem_r[idx_r];
            end else begin
              mem_read_data <= mem_read_data;
            end
          end else begin
            lat_cnt_r <= lat_cnt_r - LAT_W'(1);
          end
        end
        RESP: begin
          state_r   <= IDLE;
          mem_ready <= 1'b0;
          mem_busy  <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          mem_ready <= 1'b0;
          mem_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Line storage has no reset; a reset before the write edge drops the write.
  always_ff @(posedge clk) begin
    if (fire_s && we_r && !rst) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

`ifdef MEM_STATS_EN
  // Completion counters step on the edge entering RESP and saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (fire_s) begin
      if (we_r) begin
        if (wr_count != 16'hFFFF) begin
          wr_count <= wr_count + 16'd1;
        end
      end else if (rd_count != 16'hFFFF) begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_mesi_mem_responder.sv
// Directed bench for mesi_mem_responder (LINES=256, LATENCY=4): latency, data, aliasing,
// busy-time isolation, reset abort and statistics counters.
module tb_mesi_mem_responder;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_req = 1'b0;
  logic         mem_we = 1'b0;
  logic [31:0]  mem_addr = 32'd0;
  logic [127:0] mem_write_data = 128'd0;
  logic         mem_busy;
  logic [127:0] mem_read_data;
  logic         mem_ready;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;

  int errors = 0;
  int checks = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  localparam logic [127:0] D1 = 128'h12345678_9ABCDEF0_12345678_9ABCDEF0;
  localparam logic [127:0] D2 = 128'hCAFEF00D_00000001_CAFEF00D_00000002;
  localparam logic [127:0] DA = 128'hAAAA0000_1111AAAA_0000AAAA_A5A5A5A5;
  localparam logic [127:0] DB = 128'hBBBB0000_2222BBBB_0000BBBB_B4B4B4B4;
  localparam logic [127:0] DX = 128'h0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0;
  localparam logic [127:0] DY = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;

  mesi_mem_responder #(.LINES(256), .LATENCY(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_busy(mem_busy), .mem_read_data(mem_read_data),
    .mem_ready(mem_ready), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction; perturb changes addr/we/data right after acceptance.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [127:0] wd, input bit perturb, output logic [127:0] rd);
    int lat;
    bit busy_ok;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_write_data = wd;
    @(posedge clk);
    busy_ok = 1'b1;
    rd = 128'd0;
    if (perturb) begin
      #1;
      mem_addr = 32'h0000_0030; mem_we = 1'b1; mem_write_data = {4{32'hDEAD_BEEF}};
    end
    for (lat = 0; lat < 20; lat++) begin
      @(negedge clk);
      if (!mem_busy) busy_ok = 1'b0;
      if (mem_ready) break;
      @(posedge clk);
    end
    rd = mem_read_data;
    check({tag, "_latency"}, 128'(lat), 128'd4);
    check({tag, "_busy"}, 128'(busy_ok), 128'd1);
    if (lat < 20) begin
      if (we) exp_wr++;
      else exp_rd++;
    end
    @(posedge clk); #1;
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    check({tag, "_ready_low"}, 128'(mem_ready), 128'd0);
    check({tag, "_busy_low"}, 128'(mem_busy), 128'd0);
  endtask

  initial begin
    logic [127:0] rd;
    bit seen;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", 128'(mem_ready), 128'd0);
      check("idle_busy", 128'(mem_busy), 128'd0);
      check("idle_rdata", mem_read_data, 128'd0);
    end

    xact("wr10", 1'b1, 32'h0000_0010, D1, 1'b0, rd);
    xact("rd10", 1'b0, 32'h0000_0010, 128'd0, 1'b0, rd);
    check("rd10_data", rd, D1);

    xact("wr_alias", 1'b1, 32'h1111_1000, D2, 1'b0, rd);
    check("wr_keeps_rdata", rd, D1);
    xact("rd_alias", 1'b0, 32'h0000_1000, 128'd0, 1'b0, rd);
    check("alias_data", rd, D2);

    xact("wr20", 1'b1, 32'h0000_0020, DA, 1'b0, rd);
    xact("wr30", 1'b1, 32'h0000_0030, DB, 1'b0, rd);
    xact("rd20_pert", 1'b0, 32'h0000_0020, 128'd0, 1'b1, rd);
    check("pert_data", rd, DA);
    xact("rd30", 1'b0, 32'h0000_0030, 128'd0, 1'b0, rd);
    check("rd30_untouched", rd, DB);

    xact("wr40_old", 1'b1, 32'h0000_0040, DX, 1'b0, rd);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0040; mem_write_data = DY;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    exp_rd = 0; exp_wr = 0;
    @(negedge clk);
    check("rst_busy", 128'(mem_busy), 128'd0);
    check("rst_ready", 128'(mem_ready), 128'd0);
    check("rst_rdata", mem_read_data, 128'd0);
    check("rst_rd_count", 128'(rd_count), 128'd0);
    check("rst_wr_count", 128'(wr_count), 128'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (mem_ready) seen = 1'b1;
    end
    check("abort_no_ready", 128'(seen), 128'd0);
    xact("rd40", 1'b0, 32'h0000_0040, 128'd0, 1'b0, rd);
    check("abort_keeps_old", rd, DX);

    xact("wr50", 1'b1, 32'h0000_0050, D1, 1'b0, rd);
    xact("wr60", 1'b1, 32'h0000_0060, D2, 1'b0, rd);
    xact("wr70", 1'b1, 32'h0000_0070, DA, 1'b0, rd);
    xact("rd50", 1'b0, 32'h0000_0050, 128'd0, 1'b0, rd);
    check("rd50_data", rd, D1);
`ifdef MEM_STATS_EN
    check("wr_count", 128'(wr_count), 128'(exp_wr));
    check("rd_count", 128'(rd_count), 128'(exp_rd));
    check("wr_count_abs", 128'(wr_count), 128'd3);
    check("rd_count_abs", 128'(rd_count), 128'd2);
`else
    check("wr_count_off", 128'(wr_count), 128'd0);
    check("rd_count_off", 128'(rd_count), 128'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
